axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning bus cycles allowed per transaction before abort (min 4).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-006 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have ports cmd_addr  input  32, cmd_wdata  input  32, cmd_wstrb  input  4: byte address, write data, byte enables.
REQ-008 SHALL have ports rsp_valid  output  1, rsp_ready  input  1: response handshake.
REQ-009 SHALL have ports rsp_rdata  output  32, rsp_resp  output  2, rsp_write  output  1, rsp_timeout  output  1: read data, AXI response code, command type echo, abort flag.
REQ-010 SHALL have AXI4-Lite master ports m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, with widths 32/1/1, 32/4/1/1, 2/1/1, 32/1/1, 32/2/1/1.

Function
REQ-011 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; on accept SHALL latch all cmd_* fields and go to WR_REQ (cmd_write=1) or RD_REQ.
REQ-013 SHALL, in WR_REQ, assert awvalid and wvalid together, starting the cycle after accept.
REQ-014 SHALL deassert each of awvalid and wvalid independently, in the cycle after its own ready is sampled high.
REQ-015 SHALL go to WR_RESP once both AW and W handshakes have completed, including when both complete in the same cycle.
REQ-016 SHALL, in WR_RESP, hold bready=1 and, on bvalid, capture bresp into rsp_resp, then go to RESP.
REQ-017 SHALL, in RD_REQ, hold arvalid=1 until arready is sampled high, then go to RD_DATA.
REQ-018 SHALL, in RD_DATA, hold rready=1 and, on rvalid, capture rdata and rresp, then go to RESP.
REQ-019 SHALL hold address, data and strobe outputs constant while the corresponding valid is high.
REQ-020 SHALL never have AW/W and AR activity outstanding at the same time (one transaction in flight).
REQ-021 SHALL complete a handshake in the first valid cycle when the slave's ready is already high (zero-wait).
REQ-022 SHALL, in RESP, hold rsp_valid=1 and all rsp_* fields stable until rsp_ready, then return to IDLE.
REQ-023 SHALL have minimum write latency of 3 cycles, from accept to rsp_valid with a zero-wait slave and bvalid returned one cycle after the W handshake.
REQ-024 SHALL have minimum read latency of 3 cycles, from accept to rsp_valid with a zero-wait slave.
REQ-025 SHALL have a timeout counter that clears on accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
REQ-026 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without completion, drop all m_axi valid/ready outputs next cycle and go to RESP with rsp_resp=2'b10 and rsp_timeout=1; this is an abort and waives AXI valid-stability.
REQ-027 SHALL drive rsp_timeout=0 for normal completion and pass slave SLVERR/DECERR through unchanged.
REQ-028 SHALL size the counter as $clog2(TIMEOUT_CYCLES) bits and never let it wrap.

Reset
REQ-029 SHALL, while rst_n=1, force state IDLE, all m_axi valid/ready=0, cmd_ready=0, rsp_valid=0, rsp_* data=0, counter=0.
REQ-030 SHALL, on reset mid-transaction, discard the transaction with no response; cmd_ready rises the first cycle after release.

Structure
REQ-031 SHALL place the state enum and the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 in a shared package axi_lite_pkg.
REQ-032 SHALL be a single module; the timeout counter is inline and no sub-module is required.

Verification
REQ-033 SHALL cover: write addr 0x10, data 0xDEADBEEF, strb 0xF to a zero-wait slave -> one AW/W beat, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_write=1.
REQ-034 SHALL cover: read of addr 0x10 after REQ-033's write -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
REQ-035 SHALL cover: awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid stays high with stable awaddr until its handshake, and exactly one B is accepted.
REQ-036 SHALL cover: slave never asserts arready, TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, rsp_resp=10, rsp_timeout=1.
REQ-037 SHALL cover: rsp_ready held low 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
REQ-038 SHALL cover: rst_n pulsed while wvalid is high -> all outputs 0 during reset, no response issued, cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite command master.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle; master drives the request side, slave the response side.
interface axi_lite_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into one bus
// transaction and returns the outcome on rsp_*, aborting after TIMEOUT_CYCLES.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_write,
    output logic        rsp_timeout,
    axi_lite_if.master  m_axi
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             busy;
    logic             finish;
    logic             aw_ok;
    logic             w_ok;

    assign busy   = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    assign finish = (state == WR_RESP && m_axi.bvalid) || (state == RD_DATA && m_axi.rvalid);
    // A channel is finished once its valid has dropped or its handshake happens now.
    assign aw_ok  = !m_axi.awvalid || m_axi.awready;
    assign w_ok   = !m_axi.wvalid  || m_axi.wready;

    // NOTE: reset is active-high on rst_n and asynchronous, so it sits in the sensitivity list as posedge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_write     <= 1'b0;
            rsp_timeout   <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        timer       <= '0;
                        rsp_write   <= cmd_write;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_OKAY;
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            m_axi.awaddr  <= cmd_addr;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi.araddr  <= cmd_addr;
                            m_axi.arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi.bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RD_REQ: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_resp     <= m_axi.rresp;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides whatever the state logic above decided this cycle.
            if (busy) begin
                if (timer == CNT_MAX && !finish) begin
                    m_axi.awvalid <= 1'b0;
                    m_axi.wvalid  <= 1'b0;
                    m_axi.bready  <= 1'b0;
                    m_axi.arvalid <= 1'b0;
                    m_axi.rready  <= 1'b0;
                    rsp_rdata     <= '0;
                    rsp_resp      <= RESP_SLVERR;
                    rsp_timeout   <= 1'b1;
                    rsp_valid     <= 1'b1;
                    state         <= RESP;
                end else if (timer != CNT_MAX) begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small configurable AXI4-Lite slave.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        rsp_timeout;

    axi_lite_if m_axi ();

    axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_write  (rsp_write),
        .rsp_timeout(rsp_timeout),
        .m_axi      (m_axi)
    );

    always #5 clk = ~clk;

    // Slave configuration, written only by the stimulus block.
    int         aw_delay = 0;
    int         w_delay  = 0;
    logic       ar_enable = 1'b1;
    logic [1:0] slv_resp = 2'b00;

    int          aw_wait, w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] mem [16];
    logic        s_bvalid, s_rvalid;
    logic [31:0] s_rdata;

    assign m_axi.awready = (aw_wait >= aw_delay);
    assign m_axi.wready  = (w_wait >= w_delay);
    assign m_axi.arready = ar_enable;
    assign m_axi.bvalid  = s_bvalid;
    assign m_axi.rvalid  = s_rvalid;
    assign m_axi.rdata   = s_rdata;
    assign m_axi.bresp   = slv_resp;
    assign m_axi.rresp   = slv_resp;

    wire aw_fire = m_axi.awvalid && m_axi.awready;
    wire w_fire  = m_axi.wvalid  && m_axi.wready;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            aw_wait  <= 0;
            w_wait   <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
        end else begin
            logic [31:0] a, d;
            logic [3:0]  s;
            a = aw_fire ? m_axi.awaddr : aw_addr_q;
            d = w_fire  ? m_axi.wdata  : w_data_q;
            s = w_fire  ? m_axi.wstrb  : w_strb_q;
            if (aw_fire) begin
                aw_got    <= 1'b1;
                aw_addr_q <= m_axi.awaddr;
                aw_wait   <= 0;
            end else if (m_axi.awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_fire) begin
                w_got    <= 1'b1;
                w_data_q <= m_axi.wdata;
                w_strb_q <= m_axi.wstrb;
                w_wait   <= 0;
            end else if (m_axi.wvalid) begin
                w_wait <= w_wait + 1;
            end
            if (s_bvalid && m_axi.bready) s_bvalid <= 1'b0;
            if ((aw_got || aw_fire) && (w_got || w_fire) && !s_bvalid) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) mem[a[5:2]][8*i +: 8] <= d[8*i +: 8];
                s_bvalid <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (s_rvalid && m_axi.rready) s_rvalid <= 1'b0;
            if (m_axi.arvalid && m_axi.arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[m_axi.araddr[5:2]];
            end
        end
    end

    // Bus monitor: cumulative counts, never cleared.
    int aw_hs = 0, w_hs = 0, b_hs = 0;
    int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0;
    int stab_err = 0, overlap_err = 0;
    logic        awv_prev = 1'b0, wv_prev = 1'b0, arv_prev = 1'b0;
    logic [31:0] awaddr_prev, wdata_prev, araddr_prev;

    always @(posedge clk) begin
        if (aw_fire) aw_hs <= aw_hs + 1;
        if (w_fire)  w_hs  <= w_hs + 1;
        if (m_axi.bvalid && m_axi.bready) b_hs <= b_hs + 1;
        if (m_axi.awvalid) awv_cyc <= awv_cyc + 1;
        if (m_axi.wvalid)  wv_cyc  <= wv_cyc + 1;
        if (m_axi.arvalid) arv_cyc <= arv_cyc + 1;
        if ((m_axi.awvalid && awv_prev && m_axi.awaddr != awaddr_prev) ||
            (m_axi.wvalid  && wv_prev  && m_axi.wdata  != wdata_prev)  ||
            (m_axi.arvalid && arv_prev && m_axi.araddr != araddr_prev))
            stab_err <= stab_err + 1;
        if ((m_axi.awvalid || m_axi.wvalid || m_axi.bready) && (m_axi.arvalid || m_axi.rready))
            overlap_err <= overlap_err + 1;
        awv_prev    <= m_axi.awvalid;
        wv_prev     <= m_axi.wvalid;
        arv_prev    <= m_axi.arvalid;
        awaddr_prev <= m_axi.awaddr;
        wdata_prev  <= m_axi.wdata;
        araddr_prev <= m_axi.araddr;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output int lat);
        int guard;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    function automatic logic [10:0] ctrl_vec();
        return {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready,
                cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_resp};
    endfunction

    initial begin
        int lat;
        int aw0, w0, b0, awv0, wv0, arv0;
        logic [31:0] held;

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", ctrl_vec(), 11'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b0;
        tick();
        check("cmd_ready_after_release", cmd_ready, 1'b1);

        // Zero-wait write.
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awv0 = awv_cyc; wv0 = wv_cyc;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat);
        check("wr_latency", lat, 3);
        check("wr_resp", rsp_resp, 2'b00);
        check("wr_write_echo", rsp_write, 1'b1);
        check("wr_timeout_flag", rsp_timeout, 1'b0);
        check("wr_beats", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        check("wr_valid_cycles", {awv_cyc - awv0, wv_cyc - wv0}, {32'd1, 32'd1});
        release_rsp("wr");

        // Read back.
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        check("rd_latency", lat, 3);
        check("rd_data", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_resp", rsp_resp, 2'b00);
        check("rd_write_echo", rsp_write, 1'b0);
        release_rsp("rd");

        // Delayed AW, immediate W.
        aw_delay = 4;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awv0 = awv_cyc; wv0 = wv_cyc;
        issue(1'b1, 32'h14, 32'h1234_5678, 4'hF, lat);
        check("slow_aw_latency", lat, 7);
        check("slow_aw_valid_cycles", {awv_cyc - awv0, wv_cyc - wv0}, {32'd5, 32'd1});
        check("slow_aw_beats", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        check("slow_aw_resp", rsp_resp, 2'b00);
        release_rsp("slow_aw");
        aw_delay = 0;

        // Partial-strobe write with SLVERR passed through.
        slv_resp = 2'b10;
        issue(1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, lat);
        check("slverr_wr_resp", {rsp_resp, rsp_timeout}, {2'b10, 1'b0});
        release_rsp("slverr_wr");

        // DECERR read; response held with rsp_ready low for 5 cycles.
        slv_resp = 2'b11;
        issue(1'b0, 32'h14, 32'h0, 4'h0, lat);
        check("decerr_rd", {rsp_rdata, rsp_resp, rsp_timeout}, {32'h12BB_56DD, 2'b11, 1'b0});
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid_ready", {rsp_valid, cmd_ready}, 2'b10);
            check("hold_fields", {rsp_rdata, rsp_resp, rsp_write}, {held, 2'b11, 1'b0});
        end
        release_rsp("hold");
        slv_resp = 2'b00;

        // Slave never accepts AR.
        ar_enable = 1'b0;
        arv0 = arv_cyc;
        issue(1'b0, 32'h20, 32'h0, 4'h0, lat);
        check("to_latency", lat, 17);
        check("to_arvalid_cycles", arv_cyc - arv0, 16);
        check("to_resp", {rsp_resp, rsp_timeout, rsp_rdata}, {2'b10, 1'b1, 32'd0});
        check("to_bus_idle", {m_axi.arvalid, m_axi.rready}, 2'b00);
        release_rsp("to");
        ar_enable = 1'b1;

        // Reset while wvalid is waiting on a stalled W channel.
        w_delay = 20;
        b0 = b_hs;
        cmd_write = 1'b1;
        cmd_addr  = 32'h18;
        cmd_wdata = 32'h5555_AAAA;
        cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_wvalid_high", m_axi.wvalid, 1'b1);
        rst_n = 1'b1;
        #1;
        check("mid_async_reset", ctrl_vec(), 11'd0);
        repeat (2) tick();
        check("mid_held_reset", {ctrl_vec(), rsp_rdata}, 43'd0);
        w_delay = 0;
        rst_n = 1'b0;
        tick();
        check("mid_cmd_ready_release", cmd_ready, 1'b1);
        repeat (4) tick();
        check("mid_no_response", {rsp_valid, m_axi.bready}, 2'b00);
        check("mid_no_b", b_hs - b0, 0);

        check("valid_stability", stab_err, 0);
        check("single_outstanding", overlap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
